word_packer_2slot: RTL and testbench
====================================

Name: word_packer_2slot

Overview:
- Upstream feeder for the two-register output FIFO stage.
- Packs a narrow valid/ready byte stream into wide words and writes them with a single-cycle write strobe.
- Tracks downstream occupancy with a credit counter, so the flagless 2-deep FIFO is never overrun.
- Supports partial final words through a last flag.

Parameters:
- IN_WIDTH, 8: width of one input lane.
- RATIO, 2: input lanes per output word; legal range 2..16.
- SLOTS, 2: downstream FIFO depth, which is also the initial credit count.

Ports:
- clk  input  1: single clock, rising edge.
- rst_n  input  1: asynchronous active-low reset.
- srst  input  1: synchronous clear, active-high; must be asserted together with the downstream FIFO's srst.
- in_data  input  IN_WIDTH: input lane data.
- in_valid  input  1: input data valid.
- in_last  input  1: marks the final lane of a packet; qualified by in_valid.
- in_ready  output  1: input accept; a transfer occurs when in_valid && in_ready.
- out_din  output  IN_WIDTH*RATIO: packed word; lane 0 sits in the LSBs.
- out_last  output  1: word closes a packet; valid with out_wr.
- out_lanes  output  clog2(RATIO): number of valid lanes minus 1; valid with out_wr.
- out_wr  output  1: one-cycle write strobe to the downstream FIFO.
- out_rd  input  1: downstream FIFO read strobe; returns one credit.
- err  output  1: sticky protocol error (optional feature).

Behaviour:
- Reset state (rst_n low asynchronously, or srst high at an edge):
  - lane=0, pend=0, credits=SLOTS, asm=0.
  - out_wr=0, out_din=0, out_last=0, out_lanes=0, err=0.
- srst has priority over all other activity at the same edge. Any in-flight partial word is discarded.
- Assembly:
  - An accepted lane is written into asm[lane].
  - If lane==RATIO-1 or in_last: pend<=1, lane<=0, and last_q and lanes_q are captured. Otherwise lane<=lane+1.
  - Unused lanes of a partial word are zero. asm is cleared when the word is emitted.
- in_ready = !srst && (!pend || credits!=0). This is combinational from registers and srst only.
- Emission: at an edge where pend && credits!=0:
  - out_wr<=1; out_din, out_last and out_lanes are loaded; credits decrements; pend<=0 unless a new word completes at the same edge.
  - At all other edges out_wr<=0.
- Latency and throughput:
  - The last lane of a word accepted at edge E0 gives out_wr high after edge E1.
  - Sustained throughput is 1 word per RATIO cycles while credits are available.
- Credits:
  - Range 0..SLOTS.
  - out_rd increments; emission decrements; both at the same edge leave the count unchanged.
  - out_rd with credits==SLOTS and no emission at that edge is a protocol violation: the count saturates at SLOTS.
- Back-pressure: when credits==0 and pend==1, in_ready is low and out_wr stays low until out_rd.
- in_last on lane 0 produces a one-lane word with out_lanes=0 and out_last=1.
- in_valid without in_ready: in_data, in_last and in_valid must be held by the source. The block samples nothing.

Optional Feature:
- Macro WORD_PACKER_2SLOT_ERR_EN.
- Defined:
  - err sets at any edge where out_rd occurs with credits==SLOTS and no emission.
  - err also sets on in_valid && in_ready while lane!=0 and srst is pending; this condition is impossible by construction and serves as an assertion hook.
  - err clears only on rst_n or srst.
- Undefined: err is driven constant 0 and no error logic is synthesized.

Decomposition:
- Shared package/include holds:
  - the clog2 constant function;
  - localparams LANE_W=clog2(RATIO) and CRED_W=clog2(SLOTS+1);
  - the tag layout {out_last, out_lanes}, which the consumer concatenates into the downstream FIFO WIDTH.
- One natural sub-module, credit_cnt (parameter SLOTS), holding:
  - the saturating up/down credit counter;
  - the nonzero flag;
  - the overflow-violation pulse that feeds err.

Test Plan:
- Reset, then 4 bytes 0x11,0x22,0x33,0x44 streamed with no out_rd (RATIO=2) -> out_wr pulses carry 0x2211 then 0x4433; in_ready goes low once pend is set with credits==0; no third word appears.
- Continuing from the previous state, pulse out_rd once -> one cycle later out_wr carries the held word; credits end at 0.
- Bytes 0xAA (last=1) -> out_din=0x00AA, out_lanes=0, out_last=1; then 0xBB,0xCC (last on 0xCC) -> 0xCCBB, out_lanes=1, out_last=1.
- Continuous stream with out_rd issued every 2 cycles -> in_ready stays high and out_wr fires every 2 cycles; credits oscillate between 1 and 2 (out_rd and out_wr on the same edge leave the count unchanged).
- srst asserted after 1 of 2 lanes accepted, with credits=0 -> next cycle lane=0, credits=2, out_wr=0, and no partial word is emitted.
- With WORD_PACKER_2SLOT_ERR_EN, out_rd at credits=2 -> err=1 and stays 1 until srst; without the macro, err stays 0 and credits stay 2.

Source files
------------

// File: rtl/word_packer_2slot_pkg.sv
// Shared constants and helpers for the word_packer_2slot block.
// The optional sticky error is enabled with the WORD_PACKER_2SLOT_ERR_EN macro.
package word_packer_2slot_pkg;

  // Ceiling log2. Never returns less than 1, so the result is always a usable vector width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

  localparam int RATIO_DEF = 2;
  localparam int SLOTS_DEF = 2;
  localparam int LANE_W    = clog2(RATIO_DEF);
  localparam int CRED_W    = clog2(SLOTS_DEF + 1);

  // The downstream FIFO tag is {out_last, out_lanes}, with out_last in the MSB.
  localparam int TAG_W = 1 + LANE_W;

  function automatic int tag_width(input int ratio);
    return 1 + clog2(ratio);
  endfunction

endpackage

// File: rtl/word_packer_2slot_credit_cnt.sv
// Saturating credit counter that mirrors the occupancy of the downstream FIFO.
// ovf_o exists only when WORD_PACKER_2SLOT_ERR_EN is defined.
module credit_cnt
  import word_packer_2slot_pkg::*;
#(
  parameter int SLOTS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic srst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic nonzero_o
`ifdef WORD_PACKER_2SLOT_ERR_EN
  ,
  output logic ovf_o
`endif
);

  localparam int CW = clog2(SLOTS + 1);
  localparam logic [CW-1:0] FULL = CW'(SLOTS);

  logic [CW-1:0] count_q, count_d;

  assign nonzero_o = (count_q != '0);

`ifdef WORD_PACKER_2SLOT_ERR_EN
  assign ovf_o = inc_i && !dec_i && (count_q == FULL);
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    count_d = count_q;
    if (srst_i) begin
      count_d = FULL;
    end else if (inc_i && !dec_i) begin
      if (count_q != FULL) count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= FULL;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/word_packer_2slot.sv
// Packs a valid/ready lane stream into wide words for a flagless downstream FIFO.
// The sticky protocol error is built only when WORD_PACKER_2SLOT_ERR_EN is defined.
module word_packer_2slot
  import word_packer_2slot_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 2,
  parameter int SLOTS    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      srst,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [IN_WIDTH*RATIO-1:0] out_din,
  output logic                      out_last,
  output logic [clog2(RATIO)-1:0]   out_lanes,
  output logic                      out_wr,
  input  logic                      out_rd,
  output logic                      err
);

  localparam int LW = clog2(RATIO);
  localparam int OW = IN_WIDTH * RATIO;

  logic [LW-1:0]                    lane_q, lane_d, lanes_q, lanes_d, out_lanes_q, out_lanes_d;
  logic                             pend_q, pend_d, last_q, last_d, out_last_q, out_last_d;
  logic                             out_wr_q, out_wr_d;
  logic [RATIO-1:0][IN_WIDTH-1:0]   asm_q, asm_d;
  logic [OW-1:0]                    out_din_q, out_din_d;
  logic                             credit_nz, accept, emit;

  assign in_ready = !srst && (!pend_q || credit_nz);
  assign accept   = in_valid && in_ready;
  assign emit     = pend_q && credit_nz;

`ifdef WORD_PACKER_2SLOT_ERR_EN
  logic ovf;
`endif

  credit_cnt #(.SLOTS(SLOTS)) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .srst_i    (srst),
    .inc_i     (out_rd),
    .dec_i     (emit),
    .nonzero_o (credit_nz)
`ifdef WORD_PACKER_2SLOT_ERR_EN
    ,
    .ovf_o     (ovf)
`endif
  );

  always_comb begin
    lane_d      = lane_q;
    pend_d      = pend_q;
    last_d      = last_q;
    lanes_d     = lanes_q;
    asm_d       = asm_q;
    out_din_d   = out_din_q;
    out_last_d  = out_last_q;
    out_lanes_d = out_lanes_q;
    out_wr_d    = emit;
    // Emission clears the assembly buffer first, so a lane accepted at the same edge lands in a clean word.
    if (emit) begin
      out_din_d   = asm_q;
      out_last_d  = last_q;
      out_lanes_d = lanes_q;
      pend_d      = 1'b0;
      asm_d       = '0;
    end
    if (accept) begin
      asm_d[lane_q] = in_data;
      if (lane_q == LW'(RATIO - 1) || in_last) begin
        pend_d  = 1'b1;
        lane_d  = '0;
        last_d  = in_last;
        lanes_d = lane_q;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
    if (srst) begin
      lane_d      = '0;
      pend_d      = 1'b0;
      last_d      = 1'b0;
      lanes_d     = '0;
      asm_d       = '0;
      out_din_d   = '0;
      out_last_d  = 1'b0;
      out_lanes_d = '0;
      out_wr_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q      <= '0;
      pend_q      <= 1'b0;
      last_q      <= 1'b0;
      lanes_q     <= '0;
      asm_q       <= '0;
      out_din_q   <= '0;
      out_last_q  <= 1'b0;
      out_lanes_q <= '0;
      out_wr_q    <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      pend_q      <= pend_d;
      last_q      <= last_d;
      lanes_q     <= lanes_d;
      asm_q       <= asm_d;
      out_din_q   <= out_din_d;
      out_last_q  <= out_last_d;
      out_lanes_q <= out_lanes_d;
      out_wr_q    <= out_wr_d;
    end
  end

  assign out_din   = out_din_q;
  assign out_last  = out_last_q;
  assign out_lanes = out_lanes_q;
  assign out_wr    = out_wr_q;

`ifdef WORD_PACKER_2SLOT_ERR_EN
  logic err_q, err_d;

  // The mid-word accept term cannot fire because in_ready is low during srst; it is kept as a hook.
  always_comb begin
    err_d = err_q | ovf | (accept && (lane_q != '0) && srst);
    if (srst) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_word_packer_2slot.sv
// Self-checking bench for word_packer_2slot (RATIO=2, SLOTS=2, IN_WIDTH=8).
// Honors WORD_PACKER_2SLOT_ERR_EN when the same macro is given to the build.
module tb_word_packer_2slot;

  localparam int IW = 8;
  localparam int R  = 2;
  localparam int S  = 2;
  localparam int DW = IW * R;

`ifdef WORD_PACKER_2SLOT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, srst, in_valid, in_last, in_ready;
  logic          out_last, out_wr, out_rd, err;
  logic [IW-1:0] in_data;
  logic [DW-1:0] out_din;
  logic [0:0]    out_lanes;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  word_packer_2slot #(.IN_WIDTH(IW), .RATIO(R), .SLOTS(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .srst      (srst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_din   (out_din),
    .out_last  (out_last),
    .out_lanes (out_lanes),
    .out_wr    (out_wr),
    .out_rd    (out_rd),
    .err       (err)
  );

  // Reference model: bytes of the word under assembly, one pending word, a credit count.
  logic [IW-1:0] m_q[$];
  bit            m_pend, m_wlast, m_ready;
  logic [DW-1:0] m_word;
  int            m_wlanes, m_cred;
  bit            m_wr, m_last, m_err;
  logic [DW-1:0] m_din;
  int            m_lanes;

  task automatic m_reset();
    m_q.delete();
    m_pend = 0; m_wlast = 0; m_word = '0; m_wlanes = 0; m_cred = S;
    m_wr = 0; m_last = 0; m_din = '0; m_lanes = 0; m_err = 0;
  endtask

  task automatic m_edge(input bit s, input bit v, input logic [IW-1:0] d, input bit l,
                        input bit r, input bit rdy);
    bit emit;
    if (s) begin
      m_reset();
      return;
    end
    emit = m_pend && (m_cred > 0);
    m_wr = emit;
    if (emit) begin
      m_din = m_word; m_last = m_wlast; m_lanes = m_wlanes; m_pend = 0;
    end
    if (r && !emit && m_cred == S) m_err = m_err | ERR_EN;
    m_cred = m_cred + int'(r) - int'(emit);
    if (m_cred > S) m_cred = S;
    if (v && rdy) begin
      m_q.push_back(d);
      if (m_q.size() == R || l) begin
        m_word = '0;
        foreach (m_q[i]) m_word = m_word | (DW'(m_q[i]) << (IW * i));
        m_pend = 1; m_wlast = l; m_wlanes = m_q.size() - 1;
        m_q.delete();
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, check in_ready before the edge, advance the model, check registered outputs.
  task automatic cyc(input bit s, input bit v, input logic [IW-1:0] d, input bit l, input bit r);
    srst = s; in_valid = v; in_data = d; in_last = l; out_rd = r;
    #1;
    m_ready = !s && (!m_pend || m_cred > 0);
    check("in_ready", 32'(in_ready), 32'(m_ready));
    @(posedge clk);
    m_edge(s, v, d, l, r, m_ready);
    #1;
    check("out_wr", 32'(out_wr), 32'(m_wr));
    check("out_din", 32'(out_din), 32'(m_din));
    check("out_last", 32'(out_last), 32'(m_last));
    check("out_lanes", 32'(out_lanes), 32'(m_lanes));
    check("err", 32'(err), 32'(m_err));
  endtask

  typedef struct {
    bit            s, v;
    logic [IW-1:0] d;
    bit            l, r;
    bit            rdy, wr;
    logic [DW-1:0] din;
    bit            last, lanes;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit            hv, hacc, v, l, r, s;
    logic [IW-1:0] d;

    // s  v  d      l  r   rdy wr din       last lanes
    tbl.push_back('{0, 1, 8'h11, 0, 0, 1, 0, 16'h0000, 0, 0});
    tbl.push_back('{0, 1, 8'h22, 0, 0, 1, 0, 16'h0000, 0, 0});
    tbl.push_back('{0, 1, 8'h33, 0, 0, 1, 1, 16'h2211, 0, 1});
    tbl.push_back('{0, 1, 8'h44, 0, 0, 1, 0, 16'h2211, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 1, 16'h4433, 0, 1});
    tbl.push_back('{0, 1, 8'h55, 0, 0, 1, 0, 16'h4433, 0, 1});
    tbl.push_back('{0, 1, 8'h66, 0, 0, 1, 0, 16'h4433, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 16'h4433, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 16'h4433, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 16'h4433, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 1, 16'h6655, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 16'h6655, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 16'h6655, 0, 1});
    tbl.push_back('{0, 1, 8'hAA, 1, 0, 1, 0, 16'h6655, 0, 1});
    tbl.push_back('{0, 1, 8'hBB, 0, 0, 1, 1, 16'h00AA, 1, 0});
    tbl.push_back('{0, 1, 8'hCC, 1, 0, 1, 0, 16'h00AA, 1, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 1, 16'hCCBB, 1, 1});

    srst = 0; in_valid = 0; in_data = '0; in_last = 0; out_rd = 0;
    rst_n = 1'b0;
    m_reset();
    #12;
    check("rst_out_wr", 32'(out_wr), 32'd0);
    check("rst_out_din", 32'(out_din), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_lanes", 32'(out_lanes), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #10;
    rst_n = 1'b1;

    // Directed vectors: fill, back-pressure, credit return, partial words.
    foreach (tbl[i]) begin
      srst = tbl[i].s; in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l; out_rd = tbl[i].r;
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      m_ready = !tbl[i].s && (!m_pend || m_cred > 0);
      @(posedge clk);
      m_edge(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r, m_ready);
      #1;
      check($sformatf("tbl%0d_wr", i), 32'(out_wr), 32'(tbl[i].wr));
      check($sformatf("tbl%0d_din", i), 32'(out_din), 32'(tbl[i].din));
      check($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].last));
      check($sformatf("tbl%0d_lanes", i), 32'(out_lanes), 32'(tbl[i].lanes));
      check($sformatf("tbl%0d_err", i), 32'(err), 32'd0);
    end

    // Continuous stream with a credit return on alternate cycles: never stalls.
    cyc(0, 0, 8'h00, 0, 1);
    for (int c = 0; c < 12; c++) begin
      cyc(0, 1, 8'(c + 1), 0, (c >= 3) && (c % 2 == 1));
      check("stream_ready", 32'(in_ready), 32'd1);
      check("stream_wr", 32'(out_wr), 32'((c >= 2) && (c % 2 == 0)));
    end
    cyc(0, 0, 8'h00, 0, 0);

    // srst with one lane of a word captured and no credits left.
    cyc(1, 0, 8'h00, 0, 0);
    for (int c = 0; c < 5; c++) cyc(0, 1, 8'(8'h40 + c), 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    check("srst_wr", 32'(out_wr), 32'd0);
    check("srst_din", 32'(out_din), 32'd0);
    cyc(0, 0, 8'h00, 0, 0);
    check("srst_no_partial", 32'(out_wr), 32'd0);
    cyc(0, 1, 8'hE1, 0, 0);
    cyc(0, 1, 8'hE2, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    check("srst_fresh_word", 32'(out_din), 32'hE2E1);
    check("srst_fresh_wr", 32'(out_wr), 32'd1);

    // Excess credit return: sticky err with the feature, saturated credits either way.
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    check("ovf_err", 32'(err), 32'(ERR_EN));
    for (int c = 0; c < 3; c++) cyc(0, 0, 8'h00, 0, 0);
    check("ovf_err_sticky", 32'(err), 32'(ERR_EN));
    for (int c = 0; c < 6; c++) cyc(0, 1, 8'(8'h70 + c), 0, 0);
    check("ovf_sat_block", 32'(in_ready), 32'd0);
    cyc(1, 0, 8'h00, 0, 0);
    check("ovf_err_clear", 32'(err), 32'd0);

    // Randomized traffic against the model, with the source holding un-accepted data.
    hv = 0; hacc = 0; v = 0; d = '0; l = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!(hv && !hacc)) begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
        l = ($urandom_range(0, 3) == 0);
      end
      r = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 99) == 0);
      cyc(s, v, d, l, r);
      hv = v;
      hacc = m_ready;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
